// File: rtl/memory_data_interface_if.sv
// Load/store bus between the control unit, memory and the memory data interface.
// The master modport is the requester/memory side; the slave modport is the engine.
interface memory_data_interface_if;
  logic        start;
  logic        rw;
  logic [1:0]  size;
  logic        signed_load;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] mem_data_in;
  logic        moc;
  logic        mfa;
  logic        mem_rw;
  logic [31:0] mem_address;
  logic [3:0]  byte_enable;
  logic [31:0] mem_data_out;
  logic [31:0] mdr;
  logic        done;
  logic        misaligned;
  logic        timeout;
  logic        busy;

  modport master (
    output start, rw, size, signed_load, address, store_data, mem_data_in, moc,
    input  mfa, mem_rw, mem_address, byte_enable, mem_data_out, mdr, done, misaligned,
           timeout, busy
  );

  modport slave (
    input  start, rw, size, signed_load, address, store_data, mem_data_in, moc,
    output mfa, mem_rw, mem_address, byte_enable, mem_data_out, mdr, done, misaligned,
           timeout, busy
  );
endinterface

// File: rtl/memory_data_interface.sv
// Load/store engine: MFA/MOC handshake with big-endian byte/halfword lane alignment,
// MDR capture for loads, and done/misaligned/timeout reporting.
module memory_data_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic                    clk,
  input logic                    rst,
  memory_data_interface_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone, StError} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  count_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [1:0]  off_q;

  function automatic logic is_legal(logic [1:0] sz, logic [1:0] off);
    case (sz)
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      2'b10:   return off == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Bit 3 is the most significant byte lane (offset 0, big-endian).
  function automatic logic [3:0] lane_mask(logic [1:0] sz, logic [1:0] off);
    case (sz)
      2'b00:   return 4'b1000 >> off;
      2'b01:   return off[1] ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(logic [1:0] sz, logic [31:0] data);
    case (sz)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_align(logic [1:0] sz, logic sgn, logic [1:0] off,
                                             logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = data[31:24];
      2'd1:    b = data[23:16];
      2'd2:    b = data[15:8];
      default: b = data[7:0];
    endcase
    h = off[1] ? data[15:0] : data[31:16];
    case (sz)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return data;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      count_q          <= 8'd0;
      size_q           <= 2'b00;
      sgn_q            <= 1'b0;
      off_q            <= 2'b00;
      bus.mfa          <= 1'b0;
      bus.mem_rw       <= 1'b0;
      bus.mem_address  <= 32'd0;
      bus.byte_enable  <= 4'd0;
      bus.mem_data_out <= 32'd0;
      bus.mdr          <= 32'd0;
      bus.done         <= 1'b0;
      bus.misaligned   <= 1'b0;
      bus.timeout      <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      bus.done       <= 1'b0;
      bus.misaligned <= 1'b0;
      bus.timeout    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (is_legal(bus.size, bus.address[1:0])) begin
              state_q          <= StAccess;
              count_q          <= 8'd0;
              size_q           <= bus.size;
              sgn_q            <= bus.signed_load;
              off_q            <= bus.address[1:0];
              bus.mfa          <= 1'b1;
              bus.mem_rw       <= bus.rw;
              bus.mem_address  <= {bus.address[31:2], 2'b00};
              bus.byte_enable  <= lane_mask(bus.size, bus.address[1:0]);
              bus.mem_data_out <= bus.rw ? 32'd0 : store_lanes(bus.size, bus.store_data);
            end else begin
              state_q        <= StError;
              bus.done       <= 1'b1;
              bus.misaligned <= 1'b1;
            end
          end
        end
        StAccess: begin
          count_q <= count_q + 8'd1;
          // MOC takes priority over an expiring timeout on the same edge.
          if (bus.moc || count_q == TimeoutLast) begin
            state_q         <= StDone;
            bus.mfa         <= 1'b0;
            bus.byte_enable <= 4'd0;
            bus.done        <= 1'b1;
            bus.timeout     <= ~bus.moc;
            if (bus.moc && bus.mem_rw) begin
              bus.mdr <= load_align(size_q, sgn_q, off_q, bus.mem_data_in);
            end
          end
        end
        StDone, StError: begin
          state_q  <= StIdle;
          bus.busy <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_data_interface.sv
// Self-checking bench for memory_data_interface: vector table with a completion scoreboard.
module tb_memory_data_interface;

  localparam int unsigned Tmo = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_data_interface_if bus ();

  memory_data_interface #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] mdata;
    int          moc_at;   // ACCESS cycle in which MOC is high; 0 = never
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_dout;
    logic [31:0] exp_mdr;
    logic        exp_mis;
    logic        exp_to;
  } vec_t;

  typedef struct {
    logic [31:0] mdr;
    logic        mis;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Completion monitor: every Done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      chk("done_single_cycle", 32'(prev_done), 32'd0);
      chk("done_mfa_low", 32'(bus.mfa), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mdr", bus.mdr, e.mdr);
        chk("misaligned", 32'(bus.misaligned), 32'(e.mis));
        chk("timeout", 32'(bus.timeout), 32'(e.to));
      end
    end
    prev_done = bus.done;
  end

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   cyc;
    int   exp_cyc;
    bit   ended;
    @(posedge clk); #1;
    bus.start       = 1'b1;
    bus.rw          = v.rw;
    bus.size        = v.size;
    bus.signed_load = v.sgn;
    bus.address     = v.addr;
    bus.store_data  = v.sdata;
    bus.mem_data_in = v.mdata;
    bus.moc         = 1'b0;
    e.mdr = v.exp_mdr;
    e.mis = v.exp_mis;
    e.to  = v.exp_to;
    exp_q.push_back(e);
    @(posedge clk); #1;
    // Stray request while busy; must be ignored.
    bus.address    = 32'hFFFF_FFF0;
    bus.size       = 2'b10;
    bus.store_data = 32'h0BAD_0BAD;
    cyc   = 0;
    ended = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.mfa !== 1'b1) begin
        ended = 1'b1;
        break;
      end
      cyc++;
      if (cyc == 1) begin
        chk($sformatf("v%0d_be", idx), 32'(bus.byte_enable), 32'(v.exp_be));
        chk($sformatf("v%0d_addr", idx), bus.mem_address, v.exp_addr);
        chk($sformatf("v%0d_dout", idx), bus.mem_data_out, v.exp_dout);
        chk($sformatf("v%0d_rw", idx), 32'(bus.mem_rw), 32'(v.rw));
        chk($sformatf("v%0d_busy", idx), 32'(bus.busy), 32'd1);
      end
      if (cyc == v.moc_at) bus.moc = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.moc   = 1'b0;
    end
    bus.start = 1'b0;
    if (!ended) chk($sformatf("v%0d_mfa_stuck", idx), 32'd1, 32'd0);
    exp_cyc = v.exp_mis ? 0 : (v.moc_at == 0 ? int'(Tmo) : v.moc_at);
    chk($sformatf("v%0d_mfa_cycles", idx), 32'(cyc), 32'(exp_cyc));
    chk($sformatf("v%0d_be_idle", idx), 32'(bus.byte_enable), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[15];

  initial begin
    bus.start       = 1'b0;
    bus.rw          = 1'b0;
    bus.size        = 2'b00;
    bus.signed_load = 1'b0;
    bus.address     = 32'd0;
    bus.store_data  = 32'd0;
    bus.mem_data_in = 32'd0;
    bus.moc         = 1'b0;

    //          rw    size   sgn   addr          sdata         mdata        moc be      exp_addr      exp_dout      exp_mdr      mis   to
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 4, 4'b1111, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'b00, 1'b1, 32'h0000_0101, 32'h0,        32'h12F45678, 1, 4'b0100, 32'h0000_0100, 32'h0,        32'hFFFFFFF4, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0,        32'h12F45678, 2, 4'b0100, 32'h0000_0100, 32'h0,        32'h000000F4, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0000ABCD, 32'h55555555, 1, 4'b0011, 32'h0000_0200, 32'hABCDABCD, 32'h000000F4, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        32'h77777777, 1, 4'b0000, 32'h0,        32'h0,        32'h000000F4, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h0,        32'h77777777, 1, 4'b0000, 32'h0,        32'h0,        32'h000000F4, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h0,        32'h11111111, 0, 4'b1111, 32'h0000_0300, 32'h0,        32'h000000F4, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h0,        32'h11111111, 15, 4'b1111, 32'h0000_0300, 32'h0,       32'h11111111, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 2'b01, 1'b1, 32'h0000_0400, 32'h0,        32'h80017FFF, 2, 4'b1100, 32'h0000_0400, 32'h0,        32'hFFFF8001, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0402, 32'h0,        32'h8001F00F, 1, 4'b0011, 32'h0000_0400, 32'h0,        32'h0000F00F, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h0000_0503, 32'h123456A5, 32'h99999999, 3, 4'b0001, 32'h0000_0500, 32'hA5A5A5A5, 32'h0000F00F, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 2'b00, 1'b1, 32'h0000_0600, 32'h0,        32'h7F80FFFF, 1, 4'b1000, 32'h0000_0600, 32'h0,        32'h0000007F, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h0000_0700, 32'hCAFEF00D, 32'h33333333, 2, 4'b1111, 32'h0000_0700, 32'hCAFEF00D, 32'h0000007F, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 2'b01, 1'b1, 32'h0000_0401, 32'h0,        32'h44444444, 1, 4'b0000, 32'h0,        32'h0,        32'h0000007F, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 2'b00, 1'b0, 32'h0000_0802, 32'h0,        32'h0000C300, 1, 4'b0010, 32'h0000_0800, 32'h0,        32'h000000C3, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_mfa", 32'(bus.mfa), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_mdr", bus.mdr, 32'd0);
    chk("rst_be", 32'(bus.byte_enable), 32'd0);
    chk("rst_addr", bus.mem_address, 32'd0);
    chk("rst_dout", bus.mem_data_out, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Async reset in the middle of an access: outputs clear before the next edge, no Done.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.rw = 1'b1; bus.size = 2'b10; bus.address = 32'h0000_0900;
    bus.mem_data_in = 32'h5A5A5A5A; bus.moc = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_rst_mfa", 32'(bus.mfa), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mfa", 32'(bus.mfa), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_mdr", bus.mdr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(bus.done), 32'd0);
    end
    run_vec('{1'b1, 2'b10, 1'b0, 32'h0000_0A00, 32'h0, 32'h01234567, 2, 4'b1111,
              32'h0000_0A00, 32'h0, 32'h01234567, 1'b0, 1'b0}, 15);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_data_interface.md
Name: memory_data_interface

Overview:
Load/store engine that issues memory transactions and produces the MDR value consumed by the operand-B selection path. Given a control-unit request (address, size, sign, direction, store data), it runs the MFA/MOC handshake with memory and aligns byte and halfword data on both directions (big-endian, SPARC byte order). It captures load results into MDR and reports completion, misalignment and timeout to the control unit.

Parameters:
TIMEOUT_CYCLES, 15, maximum ACCESS cycles without MOC before abort (legal range 1..255; internal counter is 8 bits).

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  request strobe from the control unit; sampled only in IDLE.
RW  input  1  1 = load, 0 = store.
Size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
Signed_Load  input  1  1 = sign-extend a byte/halfword load; 0 = zero-extend.
Address  input  32  byte address.
Store_Data  input  32  register data to store; the value is taken from the low bits.
Mem_Data_In  input  32  read data from memory; valid when MOC = 1.
MOC  input  1  memory operation complete.
MFA  output  1  memory function active; request is held while high.
Mem_RW  output  1  latched RW, driven to memory.
Mem_Address  output  32  word-aligned address {Address[31:2], 2'b00}.
Byte_Enable  output  4  bit 3 = byte offset 0 (bits 31:24) ... bit 0 = offset 3.
Mem_Data_Out  output  32  replicated store data; 0 for loads.
MDR  output  32  aligned, extended load result.
Done  output  1  one-cycle completion pulse.
Misaligned  output  1  set with Done on an illegal size or misaligned address.
Timeout  output  1  set with Done when MOC never arrived.
Busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async): state = IDLE, timeout counter = 0, and every output = 0, including MDR.
- States: IDLE, ACCESS, DONE, ERROR.
- IDLE, Start = 1, legal request: latch RW, Size, Signed_Load, Address[1:0], Mem_Address and Store_Data; go to ACCESS next cycle.
- Legal request means: byte at any offset, halfword with Address[0] = 0, or word with Address[1:0] = 0.
- IDLE, Start = 1, illegal request: go to ERROR, which lasts one cycle. ERROR drives Done = 1 and Misaligned = 1, then returns to IDLE. MFA is never raised and MDR is unchanged.
- Start is ignored in any state other than IDLE.
- ACCESS: MFA = 1 and the latched memory outputs are stable; the counter increments every cycle.
- ACCESS, MOC = 1 at a clock edge: go to DONE. For a load, MDR is written at that edge.
- ACCESS, TIMEOUT_CYCLES edges with MOC = 0: go to DONE with Timeout = 1; MDR is unchanged.
- MOC and timeout on the same edge: MOC wins and Timeout = 0.
- DONE: Done = 1 and MFA = 0 for exactly one cycle, then IDLE. Misaligned and Timeout are valid only while Done = 1.
- Timing: Start in cycle N, MFA rises in N+1. MOC sampled at the end of cycle M gives Done and a valid MDR in M+1, and IDLE in M+2. The minimum request period is therefore 3 cycles.
- Byte_Enable, word: 1111.
- Byte_Enable, halfword: offset 0 gives 1100; offset 2 gives 0011.
- Byte_Enable, byte at offset k: only bit (3-k) is set.
- Byte_Enable is 0 outside ACCESS.
- Store data: byte stores drive {4{Store_Data[7:0]}}; halfword stores drive {2{Store_Data[15:0]}}; word stores drive Store_Data.
- Load extraction: byte at offset k is Mem_Data_In[31-8k -: 8]. Halfword at offset 0 is bits [31:16]; at offset 2 it is bits [15:0]. The result is extended to 32 bits according to Signed_Load. Words load unchanged.
- MOC outside ACCESS is ignored.
- Reset mid-ACCESS: MFA drops immediately, with no Done pulse.

Test Plan:
1. Word load, Address 0x00000100; MOC asserted 3 cycles after MFA rises, Mem_Data_In = 0xDEADBEEF -> Mem_Address 0x100, BE 1111, MDR = 0xDEADBEEF, Done high for 1 cycle, MFA high for 4 cycles.
2. Byte load, Address 0x00000101, Mem_Data_In = 0x12F45678 -> with Signed_Load = 1, MDR = 0xFFFFFFF4; with Signed_Load = 0, MDR = 0x000000F4; BE = 0100 in both cases.
3. Halfword store, Address 0x00000202, Store_Data = 0x0000ABCD -> Mem_Address 0x200, BE 0011, Mem_Data_Out 0xABCDABCD, Mem_RW 0, MDR unchanged.
4. Word load at 0x00000101, then Size = 11 at 0x0 -> each gives Done and Misaligned the next cycle; MFA stays 0; MDR unchanged; Start pulses during Busy are ignored.
5. Load with MOC held 0 -> after 15 ACCESS cycles, Done = 1 and Timeout = 1, MFA falls. Repeat with MOC arriving on edge 15 -> Timeout = 0 and MDR is updated.
6. Reset asserted asynchronously mid-ACCESS -> MFA, Busy and MDR go to 0 before the next edge, and a following word load completes normally.
